spm_port_arbiter: RTL and testbench

- Shares SPM port B between the MEM pipeline stage and a DMA/bus-slave requester.
- Sits between both requesters and the spm block's mem_spm_* port. It produces one SPM access per cycle, handles the 1-cycle synchronous read latency, and returns per-requester active-low ready (rdy_).
- MEM has fixed priority. A starvation counter guarantees DMA forward progress.

---
 rtl/spm_port_arbiter_pkg.sv | 39 +++
 rtl/spm_port_arbiter_if.sv | 45 ++++
 rtl/spm_arb_sat_cnt.sv | 31 +++
 rtl/spm_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_spm_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spm_port_arbiter_pkg.sv
// spm_port_arbiter_pkg: shared definitions for the SPM port-B arbiter.
// Provides the bus polarity/direction constants, the arbiter state and
// grant encodings, and a small saturating-increment helper.
// Optional feature macro used by the slice: SPM_ARB_STATS_EN.
package spm_port_arbiter_pkg;

  localparam int SPM_ADDR_W = 12;  // SpmAddrBus width
  localparam int SPM_DATA_W = 32;  // WordDataBus width

  localparam logic ENABLE_  = 1'b0;  // active-low strobe/ready asserted
  localparam logic DISABLE_ = 1'b1;  // active-low strobe/ready released
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  // X_RD: a read for requester X was issued in the previous cycle
  typedef enum logic [1:0] {
    SPM_ARB_IDLE   = 2'd0,
    SPM_ARB_MEM_RD = 2'd1,
    SPM_ARB_DMA_RD = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_MEM  = 2'd1,
    GRANT_DMA  = 2'd2
  } grant_e;

  // 4-bit increment that sticks at lim
  function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] lim);
    logic [3:0] res;
    if (val >= lim) begin
      res = lim;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/spm_port_arbiter_if.sv
// spm_port_arbiter_if: bundles the three buses around the arbiter.
//   mem_*  : MEM pipeline requester (as_, rw, addr, wr_data -> ; <- rd_data, rdy_)
//   dma_*  : DMA/bus-slave requester, same shape as mem_*
//   spm_*  : SPM port B (as_, rw, addr, wr_data -> ; <- rd_data, 1-cycle read latency)
// Modports: master = requester/SPM environment side, slave = arbiter side.
interface spm_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              mem_as_;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rdy_;

  logic              dma_as_;
  logic              dma_rw;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wr_data;
  logic [DATA_W-1:0] dma_rd_data;
  logic              dma_rdy_;

  logic              spm_as_;
  logic              spm_rw;
  logic [ADDR_W-1:0] spm_addr;
  logic [DATA_W-1:0] spm_wr_data;
  logic [DATA_W-1:0] spm_rd_data;

  modport master (
    output mem_as_, mem_rw, mem_addr, mem_wr_data,
    output dma_as_, dma_rw, dma_addr, dma_wr_data,
    output spm_rd_data,
    input  mem_rd_data, mem_rdy_, dma_rd_data, dma_rdy_,
    input  spm_as_, spm_rw, spm_addr, spm_wr_data
  );

  modport slave (
    input  mem_as_, mem_rw, mem_addr, mem_wr_data,
    input  dma_as_, dma_rw, dma_addr, dma_wr_data,
    input  spm_rd_data,
    output mem_rd_data, mem_rdy_, dma_rd_data, dma_rdy_,
    output spm_as_, spm_rw, spm_addr, spm_wr_data
  );
endinterface

// File: rtl/spm_arb_sat_cnt.sv
// spm_arb_sat_cnt: 16-bit event counter, saturating at 16'hFFFF, with
// synchronous clear (clr wins over inc). Only present when SPM_ARB_STATS_EN
// is defined; the default build compiles this file to nothing.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear
//   inc        : count one event this cycle
//   cnt        : registered count
`ifdef SPM_ARB_STATS_EN
module spm_arb_sat_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  // Saturating count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 16'h0000;
    end else if (clr) begin
      cnt <= 16'h0000;
    end else if (inc && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'h0001;
    end else begin
      cnt <= cnt;
    end
  end

endmodule
`endif

// File: rtl/spm_port_arbiter.sv
// spm_port_arbiter: shares SPM port B between the MEM stage and a DMA
// requester, one SPM access per cycle. MEM has fixed priority; a starvation
// counter hands DMA one arbitration after STARVE_MAX denied cycles.
// Writes are acknowledged in the grant cycle; reads are acknowledged the
// next cycle with spm_rd_data passed through.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : spm_port_arbiter_if.slave (mem_*, dma_*, spm_* groups)
// Optional (SPM_ARB_STATS_EN): stat_clr in, mem_grant_cnt / dma_grant_cnt /
//   conflict_cnt 16-bit saturating outputs.
module spm_port_arbiter
  import spm_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = SPM_ADDR_W,
  parameter int DATA_W     = SPM_DATA_W,
  parameter int STARVE_MAX = 4  // 1..15
) (
  input  logic                clk,
  input  logic                reset,
  spm_port_arbiter_if.slave   bus
`ifdef SPM_ARB_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [15:0]         mem_grant_cnt,
  output logic [15:0]         dma_grant_cnt,
  output logic [15:0]         conflict_cnt
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_e state_r;
  logic [3:0] starve_cnt_r;
  logic       mem_elig_s;
  logic       dma_elig_s;
  grant_e     grant_s;

  // Eligibility and grant; a requester whose read completes this cycle is
  // still holding as_ and must not be re-issued. Nothing issues in reset.
  always_comb begin
    mem_elig_s = (bus.mem_as_ == ENABLE_) && (state_r != SPM_ARB_MEM_RD);
    dma_elig_s = (bus.dma_as_ == ENABLE_) && (state_r != SPM_ARB_DMA_RD);
    if (reset) begin
      grant_s = GRANT_NONE;
    end else if (dma_elig_s && (starve_cnt_r == STARVE_LIM)) begin
      grant_s = GRANT_DMA;
    end else if (mem_elig_s) begin
      grant_s = GRANT_MEM;
    end else if (dma_elig_s) begin
      grant_s = GRANT_DMA;
    end else begin
      grant_s = GRANT_NONE;
    end
  end

  // SPM port B issue mux
  always_comb begin
    case (grant_s)
      GRANT_MEM: begin
        bus.spm_as_     = ENABLE_;
        bus.spm_rw      = bus.mem_rw;
        bus.spm_addr    = bus.mem_addr;
        bus.spm_wr_data = bus.mem_wr_data;
      end
      GRANT_DMA: begin
        bus.spm_as_     = ENABLE_;
        bus.spm_rw      = bus.dma_rw;
        bus.spm_addr    = bus.dma_addr;
        bus.spm_wr_data = bus.dma_wr_data;
      end
      default: begin
        bus.spm_as_     = DISABLE_;
        bus.spm_rw      = READ;
        bus.spm_addr    = {ADDR_W{1'b0}};
        bus.spm_wr_data = {DATA_W{1'b0}};
      end
    endcase
  end

  // Ready/read-data return: same-cycle write ack, next-cycle read ack.
  // rd_data is only non-zero in a read-completion cycle, where rdy_ is low.
  always_comb begin
    if (((grant_s == GRANT_MEM) && (bus.mem_rw == WRITE)) || (state_r == SPM_ARB_MEM_RD)) begin
      bus.mem_rdy_ = ENABLE_;
    end else begin
      bus.mem_rdy_ = DISABLE_;
    end
    if (((grant_s == GRANT_DMA) && (bus.dma_rw == WRITE)) || (state_r == SPM_ARB_DMA_RD)) begin
      bus.dma_rdy_ = ENABLE_;
    end else begin
      bus.dma_rdy_ = DISABLE_;
    end
    if (state_r == SPM_ARB_MEM_RD) begin
      bus.mem_rd_data = bus.spm_rd_data;
    end else begin
      bus.mem_rd_data = {DATA_W{1'b0}};
    end
    if (state_r == SPM_ARB_DMA_RD) begin
      bus.dma_rd_data = bus.spm_rd_data;
    end else begin
      bus.dma_rd_data = {DATA_W{1'b0}};
    end
  end

  // Read-outstanding FSM and DMA starvation counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= SPM_ARB_IDLE;
      starve_cnt_r <= 4'd0;
    end else begin
      case (grant_s)
        GRANT_MEM: state_r <= (bus.mem_rw == READ) ? SPM_ARB_MEM_RD : SPM_ARB_IDLE;
        GRANT_DMA: state_r <= (bus.dma_rw == READ) ? SPM_ARB_DMA_RD : SPM_ARB_IDLE;
        default:   state_r <= SPM_ARB_IDLE;
      endcase
      // DMA completing its own read is neither eligible nor idle: hold
      if ((bus.dma_as_ == DISABLE_) || (grant_s == GRANT_DMA)) begin
        starve_cnt_r <= 4'd0;
      end else if (dma_elig_s) begin
        starve_cnt_r <= sat_inc4(starve_cnt_r, STARVE_LIM);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

`ifdef SPM_ARB_STATS_EN
  spm_arb_sat_cnt u_mem_grant_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (stat_clr),
    .inc   (grant_s == GRANT_MEM),
    .cnt   (mem_grant_cnt)
  );

  spm_arb_sat_cnt u_dma_grant_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (stat_clr),
    .inc   (grant_s == GRANT_DMA),
    .cnt   (dma_grant_cnt)
  );

  spm_arb_sat_cnt u_conflict_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (stat_clr),
    .inc   (mem_elig_s && dma_elig_s && !reset),
    .cnt   (conflict_cnt)
  );
`endif

endmodule

// File: tb/tb_spm_port_arbiter.sv
// tb_spm_port_arbiter: directed + randomized bench for spm_port_arbiter.
// The bench plays both requesters and the SPM memory, and predicts every
// output each cycle from a cycle-level model of the arbitration rules.
module tb_spm_port_arbiter;
  import spm_port_arbiter_pkg::*;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef SPM_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] mem_grant_cnt, dma_grant_cnt, conflict_cnt;
  logic        clr_v = 1'b0;
  int          st_mg = 0, st_dg = 0, st_cf = 0;
  logic [15:0] o_mg, o_dg, o_cf;
`endif

  spm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SPM_ARB_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .mem_grant_cnt (mem_grant_cnt),
    .dma_grant_cnt (dma_grant_cnt),
    .conflict_cnt  (conflict_cnt)
`endif
  );

  logic [DW-1:0] spm_mem [0:4095];  // environment memory behind port B
  logic [DW-1:0] ref_mem [0:4095];  // model's view of memory contents

  int n_assert = 0;
  int n_fail   = 0;

  // requester intents
  logic          m_act = 1'b0, m_rw = READ, d_act = 1'b0, d_rw = READ;
  logic [AW-1:0] m_addr = '0, d_addr = '0;
  logic [DW-1:0] m_wd = '0, d_wd = '0;
  logic          rst_v = 1'b1;
  logic          auto_mode = 1'b0;
  logic          m_done, d_done;

  // model: who completes a read this cycle (0 none, 1 MEM, 2 DMA)
  int            pend = 0;
  logic [DW-1:0] pend_data = '0;
  int            starve = 0;

  // observations captured at the check point of the last step
  logic          o_sas, o_srw, o_mrdy, o_drdy;
  logic [AW-1:0] o_saddr;
  logic [DW-1:0] o_swd, o_mrd, o_drd;
  logic [3:0]    o_starve;
  logic [1:0]    o_state;

  function automatic logic [DW-1:0] init_word(input int a);
    return (32'(a) * 32'h0001_0003) ^ 32'hA5A5_A5A5;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_req(output logic act, output logic rw, output logic [AW-1:0] addr,
                          output logic [DW-1:0] wd);
    act  = ($urandom_range(0, 99) < 60);
    rw   = 1'($urandom_range(0, 1));
    addr = ($urandom_range(0, 9) == 0) ? 12'hFFF : AW'($urandom_range(0, 31));
    wd   = $urandom;
  endtask

  // One clock cycle: drive, predict, compare, clock, update model/memory.
  task automatic step();
    int            g;
    logic          m_el, d_el, e_sas, e_srw, e_mrdy, e_drdy;
    logic [AW-1:0] e_saddr;
    logic [DW-1:0] e_swd, e_mrd, e_drd;
    bus.mem_as_     = m_act ? 1'b0 : 1'b1;
    bus.mem_rw      = m_rw;
    bus.mem_addr    = m_addr;
    bus.mem_wr_data = m_wd;
    bus.dma_as_     = d_act ? 1'b0 : 1'b1;
    bus.dma_rw      = d_rw;
    bus.dma_addr    = d_addr;
    bus.dma_wr_data = d_wd;
    reset           = rst_v;
`ifdef SPM_ARB_STATS_EN
    stat_clr = clr_v;
`endif
    #3;
    if (rst_v) begin
      pend = 0;
      starve = 0;
`ifdef SPM_ARB_STATS_EN
      st_mg = 0; st_dg = 0; st_cf = 0;
`endif
    end
    m_el = m_act && (pend != 1) && !rst_v;
    d_el = d_act && (pend != 2) && !rst_v;
    if (d_el && starve == SMAX) g = 2;
    else if (m_el) g = 1;
    else if (d_el) g = 2;
    else g = 0;
    e_sas   = (g == 0);
    e_srw   = (g == 1) ? m_rw   : (g == 2) ? d_rw   : READ;
    e_saddr = (g == 1) ? m_addr : (g == 2) ? d_addr : '0;
    e_swd   = (g == 1) ? m_wd   : (g == 2) ? d_wd   : '0;
    e_mrdy  = !(((g == 1) && (m_rw == WRITE)) || (pend == 1));
    e_drdy  = !(((g == 2) && (d_rw == WRITE)) || (pend == 2));
    e_mrd   = (pend == 1) ? pend_data : '0;
    e_drd   = (pend == 2) ? pend_data : '0;

    o_sas = bus.spm_as_; o_srw = bus.spm_rw; o_saddr = bus.spm_addr; o_swd = bus.spm_wr_data;
    o_mrdy = bus.mem_rdy_; o_drdy = bus.dma_rdy_; o_mrd = bus.mem_rd_data; o_drd = bus.dma_rd_data;
    o_starve = dut.starve_cnt_r;
    o_state  = dut.state_r;
    check("spm_as_", 64'(o_sas), 64'(e_sas));
    check("spm_rw", 64'(o_srw), 64'(e_srw));
    check("spm_addr", 64'(o_saddr), 64'(e_saddr));
    check("spm_wr_data", 64'(o_swd), 64'(e_swd));
    check("mem_rdy_", 64'(o_mrdy), 64'(e_mrdy));
    check("dma_rdy_", 64'(o_drdy), 64'(e_drdy));
    check("mem_rd_data", 64'(o_mrd), 64'(e_mrd));
    check("dma_rd_data", 64'(o_drd), 64'(e_drd));
    check("starve_cnt", 64'(o_starve), 64'(starve));
`ifdef SPM_ARB_STATS_EN
    o_mg = mem_grant_cnt; o_dg = dma_grant_cnt; o_cf = conflict_cnt;
    check("mem_grant_cnt", 64'(o_mg), 64'(st_mg));
    check("dma_grant_cnt", 64'(o_dg), 64'(st_dg));
    check("conflict_cnt", 64'(o_cf), 64'(st_cf));
`endif
    m_done = m_act && !e_mrdy;
    d_done = d_act && !e_drdy;

    @(posedge clk);
    // SPM memory: synchronous read, data valid in the following cycle
    if (o_sas == 1'b0) begin
      if (o_srw == WRITE) spm_mem[o_saddr] = o_swd;
      else bus.spm_rd_data = spm_mem[o_saddr];
    end
    if (!rst_v) begin
      if ((g != 0) && (e_srw == READ)) begin
        pend = g;
        pend_data = ref_mem[e_saddr];
      end else begin
        pend = 0;
      end
      if ((g != 0) && (e_srw == WRITE)) ref_mem[e_saddr] = e_swd;
      if (!d_act || g == 2) starve = 0;
      else if (d_el) starve = (starve < SMAX) ? starve + 1 : SMAX;
`ifdef SPM_ARB_STATS_EN
      if (clr_v) begin
        st_mg = 0; st_dg = 0; st_cf = 0;
      end else begin
        if (g == 1 && st_mg < 65535) st_mg++;
        if (g == 2 && st_dg < 65535) st_dg++;
        if (m_el && d_el && st_cf < 65535) st_cf++;
      end
`endif
    end
    #1;
    if (auto_mode) begin
      if (m_done || !m_act) rand_req(m_act, m_rw, m_addr, m_wd);
      if (d_done || !d_act) rand_req(d_act, d_rw, d_addr, d_wd);
      rst_v = ($urandom_range(0, 299) == 0);
`ifdef SPM_ARB_STATS_EN
      clr_v = ($urandom_range(0, 99) == 0);
`endif
    end
  endtask

  initial begin
    int mi, di;
    for (int a = 0; a < 4096; a++) begin
      spm_mem[a] = init_word(a);
      ref_mem[a] = init_word(a);
    end
    bus.spm_rd_data = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // reset state
    rst_v = 1'b1;
    step();
    check("reset_state", 64'(o_state), 64'(SPM_ARB_IDLE));
    rst_v = 1'b0;

    // MEM write 0x010 then read it back
    m_act = 1'b1; m_rw = WRITE; m_addr = 12'h010; m_wd = 32'hDEAD_BEEF;
    step();
    check("wr_same_cycle_as", 64'(o_sas), 64'(1'b0));
    check("wr_same_cycle_rdy", 64'(o_mrdy), 64'(1'b0));
    m_act = 1'b0;
    step();
    m_act = 1'b1; m_rw = READ;
    step();
    check("rd_issue_rdy", 64'(o_mrdy), 64'(1'b1));
    step();
    check("rd_done_rdy", 64'(o_mrdy), 64'(1'b0));
    check("rd_done_data", 64'(o_mrd), 64'(32'hDEAD_BEEF));
    m_act = 1'b0;

    // both read continuously: grants alternate, no idle slot
    mi = 0; di = 0;
    m_act = 1'b1; m_rw = READ; m_addr = 12'h100;
    d_act = 1'b1; d_rw = READ; d_addr = 12'h200;
    for (int k = 0; k < 8; k++) begin
      step();
      check("alt_as", 64'(o_sas), 64'(1'b0));
      check("alt_addr", 64'(o_saddr), (k % 2 == 0) ? 64'(12'h100 + k / 2) : 64'(12'h200 + k / 2));
      if (k % 2 == 1) check("alt_mem_done", 64'(o_mrdy), 64'(1'b0));
      if (m_done) begin mi++; m_addr = AW'(12'h100 + mi); end
      if (d_done) begin di++; d_addr = AW'(12'h200 + di); end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      if (m_done) m_act = 1'b0;
      if (d_done) d_act = 1'b0;
    end

    // MEM streams writes, DMA read of 0x020 starves then wins
    mi = 0;
    m_act = 1'b1; m_rw = WRITE; m_addr = 12'h300; m_wd = $urandom;
    d_act = 1'b1; d_rw = READ; d_addr = 12'h020;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) begin
        check("starve_deny_addr", 64'(o_saddr), 64'(12'h300 + c - 1));
        check("starve_deny_rdy", 64'(o_drdy), 64'(1'b1));
      end else if (c == 5) begin
        check("starve_win_addr", 64'(o_saddr), 64'(12'h020));
        check("starve_win_rw", 64'(o_srw), 64'(READ));
      end else begin
        check("starve_rdy", 64'(o_drdy), 64'(1'b0));
        check("starve_data", 64'(o_drd), 64'(init_word(32)));
        check("starve_clr", 64'(o_starve), 64'(4'd0));
      end
      if (m_done) begin mi++; m_addr = AW'(12'h300 + mi); m_wd = $urandom; end
      if (d_done) d_act = 1'b0;
    end
    m_act = 1'b0;
    step();

    // reset during MEM_RD discards the read; held request reissues
    m_act = 1'b1; m_rw = READ; m_addr = 12'h010;
    step();
    rst_v = 1'b1;
    step();
    check("rst_rd_rdy", 64'(o_mrdy), 64'(1'b1));
    check("rst_rd_as", 64'(o_sas), 64'(1'b1));
    check("rst_rd_state", 64'(o_state), 64'(SPM_ARB_IDLE));
    rst_v = 1'b0;
    step();
    check("rst_reissue_addr", 64'(o_saddr), 64'(12'h010));
    step();
    check("rst_reissue_data", 64'(o_mrd), 64'(32'hDEAD_BEEF));
    m_act = 1'b0;

    // DMA write 0x7FF during MEM read completion
    m_act = 1'b1; m_rw = READ; m_addr = 12'h010;
    step();
    d_act = 1'b1; d_rw = WRITE; d_addr = 12'h7FF; d_wd = 32'h1234_5678;
    step();
    check("cmpl_wr_addr", 64'(o_saddr), 64'(12'h7FF));
    check("cmpl_wr_dma_rdy", 64'(o_drdy), 64'(1'b0));
    check("cmpl_wr_mem_rdy", 64'(o_mrdy), 64'(1'b0));
    m_act = 1'b0; d_act = 1'b0;
    m_act = 1'b1; m_rw = READ; m_addr = 12'h7FF;
    step();
    step();
    check("rd_7ff_data", 64'(o_mrd), 64'(32'h1234_5678));
    m_act = 1'b0;
    step();

`ifdef SPM_ARB_STATS_EN
    // 10 conflict cycles, then clear
    clr_v = 1'b1;
    step();
    clr_v = 1'b0;
    mi = 0; di = 0;
    m_act = 1'b1; m_rw = WRITE; m_addr = 12'h400;
    d_act = 1'b1; d_rw = WRITE; d_addr = 12'h500;
    for (int k = 0; k < 10; k++) begin
      step();
      if (m_done) begin mi++; m_addr = AW'(12'h400 + mi); end
      if (d_done) begin di++; d_addr = AW'(12'h500 + di); end
    end
    m_act = 1'b0; d_act = 1'b0;
    step();
    check("conflict_10", 64'(o_cf), 64'(16'd10));
    clr_v = 1'b1;
    step();
    clr_v = 1'b0;
    step();
    check("clr_mem_cnt", 64'(o_mg), 64'(16'd0));
    check("clr_dma_cnt", 64'(o_dg), 64'(16'd0));
    check("clr_conflict", 64'(o_cf), 64'(16'd0));
`endif

    // randomized traffic against the model
    auto_mode = 1'b1;
    for (int n = 0; n < 3000; n++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
